// File: rtl/la_vrrarb_pkg.sv
// la_vrrarb_pkg
//   Shared definitions for the la_vrrarb round-robin packet-locking arbiter.
//   - state_t     : arbiter state encoding (IDLE = 1'b0, LOCK = 1'b1)
//   - ptr_width() : width of the round-robin pointer, max(1, $clog2(n))
//   Build option used by la_vrrarb: LA_VRRARB_OUTREG_EN (registered output stage).
package la_vrrarb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  // A single requester still needs a 1-bit pointer so the port is never zero-width.
  function automatic int ptr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/la_vmux.sv
// la_vmux
//   One-hot vector multiplexer: out is the OR of every input lane whose select
//   bit is set. With an all-zero select the output is zero.
//   Parameters: N lanes, W bits per lane, PROP cell property (library hint).
//   Ports:
//     sel [N-1:0]   one-hot lane select
//     in  [W*N-1:0] concatenated lanes {.., in1, in0}
//     out [W-1:0]   selected lane
module la_vmux #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter     PROP = "DEFAULT"
) (
  input  logic [N-1:0]   sel,
  input  logic [W*N-1:0] in,
  output logic [W-1:0]   out
);

  logic [W-1:0] masked [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign masked[gi] = in[gi*W +: W] & {W{sel[gi]}};
  end

  always_comb begin
    out = '0;
    for (int i = 0; i < N; i++) begin
      out = out | masked[i];
    end
  end

endmodule

// File: rtl/la_vrrarb_pick.sv
// la_vrrarb_pick
//   Combinational round-robin picker. Scans req starting at index ptr, wrapping
//   from N-1 back to 0, and returns the first set bit.
//   Ports:
//     req [N-1:0]  request vector
//     ptr [PW-1:0] highest-priority index
//     gnt [N-1:0]  one-hot winner (zero when req is zero)
//     idx [PW-1:0] binary index of the winner (zero when req is zero)
module la_vrrarb_pick
  import la_vrrarb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  always_comb begin
    logic found;
    int   j;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/la_vrrarb.sv
// la_vrrarb
//   Round-robin, packet-locking arbiter: N requester streams share one W-bit
//   output channel. A winner keeps the channel until its last beat is accepted;
//   the next owner is picked in the same cycle so packets run back to back.
//   Build option: LA_VRRARB_OUTREG_EN adds a 1-entry register on out_*.
//   Ports:
//     clk, reset            clock and synchronous active-high reset
//     in_valid/in_last [N]  per-requester beat valid / end of packet
//     in_data [W*N]         concatenated {.., in1, in0}
//     in_ready [N]          per-requester accept (only the owner's bit can be 1)
//     out_valid/out_last    output beat valid / end of packet
//     out_data [W]          output beat
//     out_ready             consumer accept
//     grant [N]             registered one-hot owner, 0 when idle
//     busy                  arbiter is locked to an owner
module la_vrrarb
  import la_vrrarb_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter     PROP = "DEFAULT"
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   in_valid,
  input  logic [N-1:0]   in_last,
  input  logic [W*N-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic           out_last,
  output logic [W-1:0]   out_data,
  input  logic           out_ready,
  output logic [N-1:0]   grant,
  output logic           busy
);

  localparam int PW = ptr_width(N);

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] owner_q, owner_d;

  logic [PW-1:0] ptr_next;
  logic [N-1:0]  pick_req, pick_gnt;
  logic [PW-1:0] pick_ptr, pick_idx;
  logic [W-1:0]  mux_data;
  logic          mux_valid, mux_last;
  logic          stage_ready;
  logic [N-1:0]  accept;
  logic          last_accept;

  // Pointer after the current owner finishes; wraps N-1 -> 0 (always 0 for N = 1).
  assign ptr_next = (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;

  // In IDLE everyone competes from ptr_q. In LOCK the picker is only consulted
  // at last accept: the finishing owner is masked out and the new pointer applies.
  assign pick_req = (state_q == IDLE) ? in_valid : (in_valid & ~grant_q);
  assign pick_ptr = (state_q == IDLE) ? ptr_q : ptr_next;

  la_vrrarb_pick #(.N(N), .PW(PW)) u_pick (
    .req (pick_req),
    .ptr (pick_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  la_vmux #(.N(N), .W(W), .PROP(PROP)) u_mux (
    .sel (grant_q),
    .in  (in_data),
    .out (mux_data)
  );

  assign mux_valid = |(grant_q & in_valid);
  assign mux_last  = |(grant_q & in_last);

`ifdef LA_VRRARB_OUTREG_EN
  logic         out_valid_q, out_valid_d;
  logic         out_last_q, out_last_d;
  logic [W-1:0] out_data_q, out_data_d;

  // The stage can take a new beat when empty or when its beat leaves this cycle.
  assign stage_ready = ~out_valid_q | out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    if (stage_ready) begin
      out_valid_d = mux_valid;
      out_last_d  = mux_last;
      out_data_d  = mux_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
`else
  assign stage_ready = out_ready;
  assign out_valid   = mux_valid;
  assign out_last    = mux_last;
  assign out_data    = mux_data;
`endif

  assign in_ready = grant_q & {N{stage_ready}};

  // Packet completion is judged on the input side, so with the output register
  // re-arbitration overlaps the final output beat.
  assign accept      = grant_q & in_valid & in_ready;
  assign last_accept = |(accept & in_last);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (|in_valid) begin
          grant_d = pick_gnt;
          owner_d = pick_idx;
          state_d = LOCK;
        end
      end
      LOCK: begin
        // An owner that drops valid mid-packet simply holds the lock.
        if (last_accept) begin
          ptr_d = ptr_next;
          if (|pick_req) begin
            grant_d = pick_gnt;
            owner_d = pick_idx;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == LOCK);

endmodule

// File: tb/tb_la_vrrarb.sv
module tb_la_vrrarb;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [N-1:0]   in_valid, in_last, in_ready, grant;
  logic [W*N-1:0] in_data;
  logic           out_valid, out_last, out_ready, busy;
  logic [W-1:0]   out_data;

  logic           v1, l1, r1, ov1, ol1, ordy1, b1;
  logic [15:0]    d1, od1;
  logic [0:0]     g1;

  int errors = 0;
  int checks = 0;

  logic [8:0]  q0 [$];
  logic [16:0] q1 [$];
  logic [3:0]  s1_g [5];

  la_vrrarb #(.N(N), .W(W), .PROP("DEFAULT")) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_last(out_last), .out_data(out_data), .out_ready(out_ready),
    .grant(grant), .busy(busy)
  );

  la_vrrarb #(.N(1), .W(16), .PROP("DEFAULT")) dut1 (
    .clk(clk), .reset(reset),
    .in_valid(v1), .in_last(l1), .in_data(d1), .in_ready(r1),
    .out_valid(ov1), .out_last(ol1), .out_data(od1), .out_ready(ordy1),
    .grant(g1), .busy(b1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic lane(input int i, input logic [7:0] v);
    in_data[i*W +: W] = v;
  endtask

  // One clock: scoreboard both outputs at the falling edge, then move past the
  // rising edge so new stimulus lands clear of it.
  task automatic tick();
    logic [8:0]  e0;
    logic [16:0] e1;
    @(negedge clk);
    if (out_valid && out_ready) begin
      chk("sb0_pending", 32'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        e0 = q0.pop_front();
        chk("sb0_beat", {out_last, out_data}, e0);
      end
    end
    if (ov1 && ordy1) begin
      chk("sb1_pending", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        chk("sb1_beat", {ol1, od1}, e1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int beat;
    int c;
    s1_g = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001};
    reset = 1'b1; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
    v1 = 1'b0; l1 = 1'b0; d1 = '0; ordy1 = 1'b0;
    tick(); tick();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_ptr", dut.ptr_q, 0);
    chk("rst_grant_n1", g1, 0);
    reset = 1'b0;

    // Alternating single-beat packets from requesters 0 and 2.
    in_valid = 4'b0101; in_last = 4'b1111; lane(0, 8'hA0); lane(2, 8'hC2); out_ready = 1'b1;
    #1;
    chk("s1_idle_grant", grant, 0);
    chk("s1_idle_valid", out_valid, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) in_valid = 4'b0001;
      #1;
      chk("s1_grant", grant, s1_g[i]);
      q0.push_back({1'b1, (s1_g[i] == 4'b0001) ? 8'hA0 : 8'hC2});
      tick();
    end
    in_valid = '0;
    #1;
    chk("s1_end_grant", grant, 0);
    chk("s1_end_busy", busy, 0);

    // Requester 1 sends 3 beats while requester 3 waits.
    in_valid = 4'b1010; in_last = 4'b1000; lane(1, 8'h10); lane(3, 8'h30);
    #1;
    chk("s2_idle_grant", grant, 0);
    tick();
    for (int b = 0; b < 3; b++) begin
      lane(1, 8'(8'h10 + b));
      in_last[1] = (b == 2);
      #1;
      chk("s2_grant", grant, 4'b0010);
      chk("s2_rdy3", in_ready[3], 0);
      q0.push_back({(b == 2), 8'(8'h10 + b)});
      tick();
    end
    in_valid = 4'b1000;
    #1;
    chk("s2_handoff", grant, 4'b1000);
    q0.push_back({1'b1, 8'h30});
    tick();
    in_valid = '0;
    #1;
    chk("s2_end_grant", grant, 0);

    // Stalling consumer during a 4-beat packet from requester 0.
    in_valid = 4'b0001; in_last = '0; lane(0, 8'h40); out_ready = 1'b1;
    tick();
    beat = 0;
    c = 0;
    while (beat < 4 && c < 16) begin
      out_ready = (c % 2 == 0);
      lane(0, 8'(8'h40 + beat));
      in_last[0] = (beat == 3);
      #1;
      if (out_ready) begin
        q0.push_back({(beat == 3), 8'(8'h40 + beat)});
      end else begin
        chk("s3_hold_data", out_data, 8'(8'h40 + beat));
        chk("s3_hold_rdy", in_ready, 0);
      end
      tick();
      if (out_ready) beat++;
      c++;
    end
    out_ready = 1'b1; in_valid = '0; in_last = '0;
    #1;
    chk("s3_end_grant", grant, 0);

    // Owner 2 pauses mid-packet while requester 0 waits.
    in_valid = 4'b0101; in_last = 4'b0001; lane(0, 8'h60); lane(2, 8'h50);
    tick();
    #1;
    chk("s4_grant", grant, 4'b0100);
    q0.push_back({1'b0, 8'h50});
    tick();
    for (int k = 0; k < 2; k++) begin
      in_valid = 4'b0001;
      #1;
      chk("s4_gap_busy", busy, 1);
      chk("s4_gap_grant", grant, 4'b0100);
      chk("s4_gap_valid", out_valid, 0);
      tick();
    end
    in_valid = 4'b0101; lane(2, 8'h51);
    #1;
    chk("s4_resume_grant", grant, 4'b0100);
    q0.push_back({1'b0, 8'h51});
    tick();
    lane(2, 8'h52); in_last = 4'b0101;
    q0.push_back({1'b1, 8'h52});
    tick();
    in_valid = 4'b0001;
    #1;
    chk("s4_next_grant", grant, 4'b0001);
    q0.push_back({1'b1, 8'h60});
    tick();
    in_valid = '0; in_last = '0;
    #1;
    chk("s4_end_grant", grant, 0);

    // Reset in the middle of a packet from requester 3.
    in_valid = 4'b1000; lane(3, 8'h70);
    tick();
    #1;
    chk("s5_grant", grant, 4'b1000);
    q0.push_back({1'b0, 8'h70});
    tick();
    lane(3, 8'h71); reset = 1'b1;
    #1;
    q0.push_back({1'b0, 8'h71});
    tick();
    reset = 1'b0; in_valid = 4'b1010; in_last = 4'b1010; lane(1, 8'h80); lane(3, 8'h73);
    #1;
    chk("s5_rst_grant", grant, 0);
    chk("s5_rst_valid", out_valid, 0);
    chk("s5_rst_busy", busy, 0);
    chk("s5_rst_ptr", dut.ptr_q, 0);
    tick();
    #1;
    chk("s5_pick_lowest", grant, 4'b0010);
    q0.push_back({1'b1, 8'h80});
    tick();
    in_valid = 4'b1000;
    #1;
    chk("s5_then3", grant, 4'b1000);
    q0.push_back({1'b1, 8'h73});
    tick();
    in_valid = '0; in_last = '0;
    #1;
    chk("s5_end_grant", grant, 0);

    // Single requester: every packet passes through IDLE, one bubble each.
    v1 = 1'b1; l1 = 1'b1; ordy1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      d1 = 16'(16'hA000 + k);
      #1;
      chk("s6_grant", g1, k % 2);
      chk("s6_valid", ov1, k % 2);
      if (k % 2 == 1) q1.push_back({1'b1, d1});
      tick();
    end
    v1 = 1'b0;
    #1;
    chk("s6_end_grant", g1, 0);

    chk("sb0_drained", q0.size(), 0);
    chk("sb1_drained", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
